// File: rtl/demux_1ton_hs_if.sv
// ----------------------------------------------------------------------------
// demux_1ton_hs_if
//   Bundles the input handshake, the per-channel output handshakes and the
//   drop-reporting status of the 1:N demultiplexer.
//   master : producer/consumer side (drives d, d_valid, s, bcast, y_ready)
//   slave  : demultiplexer side (drives d_ready, y, y_valid, err_sel, drop_cnt)
//   SEL_W is derived from N_OUT and cannot be overridden.
// ----------------------------------------------------------------------------
interface demux_1ton_hs_if #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int CNT_W = 8
);
    localparam int SEL_W = $clog2(N_OUT);

    logic [WIDTH-1:0]       d;
    logic                   d_valid;
    logic                   d_ready;
    logic [SEL_W-1:0]       s;
    logic                   bcast;
    logic [N_OUT*WIDTH-1:0] y;
    logic [N_OUT-1:0]       y_valid;
    logic [N_OUT-1:0]       y_ready;
    logic                   err_sel;
    logic [CNT_W-1:0]       drop_cnt;

    modport master (
        output d, d_valid, s, bcast, y_ready,
        input  d_ready, y, y_valid, err_sel, drop_cnt
    );

    modport slave (
        input  d, d_valid, s, bcast, y_ready,
        output d_ready, y, y_valid, err_sel, drop_cnt
    );
endinterface

// File: rtl/demux_1ton_hs.sv
// ----------------------------------------------------------------------------
// demux_1ton_hs
//   Registered 1:N demultiplexer with valid/ready handshakes. Each output
//   channel owns a single-entry buffer. An accepted word is written into the
//   channel chosen by s, or into every channel when bcast=1, and shows up on
//   the edge after acceptance. A select that names no channel drains the word,
//   pulses err_sel for one cycle and bumps a saturating drop counter.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    demux_1ton_hs_if.slave (d/d_valid/d_ready/s/bcast in,
//            y/y_valid/y_ready per channel, err_sel, drop_cnt)
// ----------------------------------------------------------------------------
module demux_1ton_hs #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    demux_1ton_hs_if.slave  bus
);

    logic [N_OUT*WIDTH-1:0] y_q, y_d;
    logic [N_OUT-1:0]       y_valid_q, y_valid_d;
    logic                   err_sel_q, err_sel_d;
    logic [CNT_W-1:0]       drop_cnt_q, drop_cnt_d;

    logic [N_OUT-1:0]       free_s;
    logic [N_OUT-1:0]       load_s;
    logic                   sel_legal_s;
    logic                   sel_free_s;
    logic                   d_ready_s;
    logic                   accept_s;
    logic                   drop_s;

    // Ready/accept decode: a channel is free when empty or draining this cycle,
    // so consumer ready passes straight through to d_ready.
    always_comb begin
        free_s      = ~y_valid_q | bus.y_ready;
        sel_legal_s = (32'(bus.s) < 32'(N_OUT));
        sel_free_s  = 1'b0;
        for (int i = 0; i < N_OUT; i++) begin
            if (32'(bus.s) == 32'(i)) begin
                sel_free_s = free_s[i];
            end else begin
                sel_free_s = sel_free_s;
            end
        end

        if (bus.bcast) begin
            d_ready_s = &free_s;
        end else if (sel_legal_s) begin
            d_ready_s = sel_free_s;
        end else begin
            // Nobody owns this word; always take it so the source never stalls.
            d_ready_s = 1'b1;
        end

        accept_s = bus.d_valid && d_ready_s;
        drop_s   = accept_s && !bus.bcast && !sel_legal_s;

        for (int i = 0; i < N_OUT; i++) begin
            load_s[i] = accept_s && (bus.bcast || (32'(bus.s) == 32'(i)));
        end
    end

    // Next-state for channel buffers, error pulse and drop counter.
    always_comb begin
        y_d        = y_q;
        y_valid_d  = y_valid_q;
        err_sel_d  = drop_s;
        drop_cnt_d = drop_cnt_q;

        for (int i = 0; i < N_OUT; i++) begin
            if (load_s[i]) begin
                // A load wins over a same-cycle drain: no bubble between words.
                y_d[i*WIDTH +: WIDTH] = bus.d;
                y_valid_d[i]          = 1'b1;
            end else if (y_valid_q[i] && bus.y_ready[i]) begin
                // Data is left in place; only the valid flag drops.
                y_valid_d[i] = 1'b0;
            end else begin
                y_valid_d[i] = y_valid_q[i];
            end
        end

        if (drop_s && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q        <= {(N_OUT*WIDTH){1'b0}};
            y_valid_q  <= {N_OUT{1'b0}};
            err_sel_q  <= 1'b0;
            drop_cnt_q <= {CNT_W{1'b0}};
        end else begin
            y_q        <= y_d;
            y_valid_q  <= y_valid_d;
            err_sel_q  <= err_sel_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.d_ready  = d_ready_s;
    assign bus.y        = y_q;
    assign bus.y_valid  = y_valid_q;
    assign bus.err_sel  = err_sel_q;
    assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux_1ton_hs.sv
module tb_demux_1ton_hs;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;
    int   exp_cnt;

    demux_1ton_hs_if #(.WIDTH(8), .N_OUT(4), .CNT_W(8)) if4 ();
    demux_1ton_hs_if #(.WIDTH(8), .N_OUT(3), .CNT_W(8)) if3 ();

    demux_1ton_hs #(.WIDTH(8), .N_OUT(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(if4)
    );
    demux_1ton_hs #(.WIDTH(8), .N_OUT(3), .CNT_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: one queue of outstanding words per channel of the 4-channel DUT.
    logic [7:0] sb [4][$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One random cycle on the 4-channel DUT, checked against the queues.
    task automatic rand_cycle(input logic drain_only);
        logic [3:0] rdy;
        logic       vld;
        logic       bc;
        logic [1:0] sel;
        logic [7:0] dat;
        logic       exp_rdy;
        logic [3:0] fr;
        rdy = drain_only ? 4'b1111 : 4'($urandom_range(0, 15));
        vld = drain_only ? 1'b0 : 1'($urandom_range(0, 3) != 0);
        bc  = ($urandom_range(0, 7) == 0);
        sel = 2'($urandom_range(0, 3));
        dat = 8'($urandom);
        if4.y_ready = rdy;
        if4.d_valid = vld;
        if4.bcast   = bc;
        if4.s       = sel;
        if4.d       = dat;
        #1;
        for (int i = 0; i < 4; i++) begin
            fr[i] = (sb[i].size() == 0) || rdy[i];
            chk($sformatf("rnd_valid%0d", i), 64'(if4.y_valid[i]), 64'(sb[i].size() != 0));
            if (sb[i].size() != 0) begin
                chk($sformatf("rnd_data%0d", i), 64'(if4.y[i*8 +: 8]), 64'(sb[i][0]));
            end
        end
        exp_rdy = bc ? (&fr) : fr[sel];
        chk("rnd_d_ready", 64'(if4.d_ready), 64'(exp_rdy));
        for (int i = 0; i < 4; i++) begin
            if ((sb[i].size() != 0) && rdy[i]) begin
                void'(sb[i].pop_front());
            end
            if (vld && exp_rdy && (bc || (sel == 2'(i)))) begin
                sb[i].push_back(dat);
            end
        end
        step();
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        exp_cnt     = 0;
        rst_n       = 1'b0;
        if4.d = 8'h00; if4.d_valid = 1'b0; if4.s = 2'd0; if4.bcast = 1'b0; if4.y_ready = 4'b0000;
        if3.d = 8'h00; if3.d_valid = 1'b0; if3.s = 2'd0; if3.bcast = 1'b0; if3.y_ready = 3'b111;
        #22 rst_n = 1'b1;
        step();

        // Reset state after power-up
        chk("rst_y_valid", 64'(if4.y_valid), 64'h0);
        chk("rst_drop_cnt", 64'(if3.drop_cnt), 64'h0);

        // Load state, then async reset between edges must clear it at once
        if4.d_valid = 1'b1; if4.s = 2'd2; if4.d = 8'hA5;
        if3.d_valid = 1'b1; if3.s = 2'd3; if3.d = 8'h5A;
        step();
        if4.d_valid = 1'b0; if3.d_valid = 1'b0;
        #1;
        chk("pre_rst_y_valid", 64'(if4.y_valid), 64'h4);
        chk("pre_rst_drop", 64'(if3.drop_cnt), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_y_valid", 64'(if4.y_valid), 64'h0);
        chk("async_rst_y", 64'(if4.y), 64'h0);
        chk("async_rst_drop", 64'(if3.drop_cnt), 64'h0);
        chk("async_rst_err", 64'(if3.err_sel), 64'h0);
        #2 rst_n = 1'b1;
        step();

        // Routing: single word to channel 2, visible one cycle
        if4.y_ready = 4'b1111;
        if4.d_valid = 1'b1; if4.s = 2'd2; if4.d = 8'hA5;
        #1;
        chk("route_d_ready", 64'(if4.d_ready), 64'h1);
        step();
        if4.d_valid = 1'b0;
        #1;
        chk("route_y_valid", 64'(if4.y_valid), 64'h4);
        chk("route_y2", 64'(if4.y[23:16]), 64'hA5);
        step();
        chk("route_one_cycle", 64'(if4.y_valid), 64'h0);

        // Backpressure on channel 1, then back-to-back with no bubble
        if4.y_ready = 4'b1101;
        if4.d_valid = 1'b1; if4.s = 2'd1; if4.d = 8'h11;
        step();
        if4.d = 8'h22;
        #1;
        chk("bp_block", 64'(if4.d_ready), 64'h0);
        chk("bp_hold_data", 64'(if4.y[15:8]), 64'h11);
        step();
        chk("bp_still_block", 64'(if4.d_ready), 64'h0);
        chk("bp_still_data", 64'(if4.y[15:8]), 64'h11);
        chk("bp_still_valid", 64'(if4.y_valid), 64'h2);
        if4.y_ready = 4'b1111;
        #1;
        chk("bp_release", 64'(if4.d_ready), 64'h1);
        step();
        if4.d = 8'h33;
        #1;
        chk("b2b_valid", 64'(if4.y_valid), 64'h2);
        chk("b2b_data1", 64'(if4.y[15:8]), 64'h22);
        chk("b2b_ready", 64'(if4.d_ready), 64'h1);
        step();
        if4.d_valid = 1'b0;
        #1;
        chk("b2b_data2", 64'(if4.y[15:8]), 64'h33);
        chk("b2b_valid2", 64'(if4.y_valid), 64'h2);
        step();
        chk("b2b_drained", 64'(if4.y_valid), 64'h0);

        // Broadcast blocked by a full channel 2
        if4.y_ready = 4'b1011;
        if4.d_valid = 1'b1; if4.s = 2'd2; if4.d = 8'h77;
        step();
        if4.bcast = 1'b1; if4.d = 8'h3C; if4.s = 2'd0;
        #1;
        chk("bc_block", 64'(if4.d_ready), 64'h0);
        step();
        chk("bc_block2", 64'(if4.d_ready), 64'h0);
        chk("bc_ch2_hold", 64'(if4.y[23:16]), 64'h77);
        if4.y_ready = 4'b1111;
        #1;
        chk("bc_release", 64'(if4.d_ready), 64'h1);
        step();
        if4.d_valid = 1'b0; if4.bcast = 1'b0; if4.y_ready = 4'b0000;
        #1;
        chk("bc_all_valid", 64'(if4.y_valid), 64'hF);
        chk("bc_all_data", 64'(if4.y), 64'h3C3C3C3C);
        step();
        chk("bc_stable", 64'(if4.y_valid), 64'hF);
        if4.y_ready = 4'b0101;
        step();
        chk("bc_partial_drain", 64'(if4.y_valid), 64'hA);
        if4.y_ready = 4'b1111;
        step();
        chk("bc_drained", 64'(if4.y_valid), 64'h0);

        // Legal word on the 3-channel DUT
        if3.d_valid = 1'b1; if3.s = 2'd1; if3.d = 8'h96;
        step();
        if3.d_valid = 1'b0;
        #1;
        chk("n3_valid", 64'(if3.y_valid), 64'h2);
        chk("n3_data", 64'(if3.y[15:8]), 64'h96);
        chk("n3_err", 64'(if3.err_sel), 64'h0);
        step();

        // Illegal select: 300 dropped words, counter saturates at 255
        for (int k = 0; k < 300; k++) begin
            if3.d_valid = 1'b1; if3.s = 2'd3; if3.d = 8'(k);
            #1;
            chk("ill_d_ready", 64'(if3.d_ready), 64'h1);
            step();
            if3.d_valid = 1'b0;
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            #1;
            chk("ill_err_pulse", 64'(if3.err_sel), 64'h1);
            chk("ill_no_valid", 64'(if3.y_valid), 64'h0);
            chk("ill_drop_cnt", 64'(if3.drop_cnt), 64'(exp_cnt));
            step();
            chk("ill_err_low", 64'(if3.err_sel), 64'h0);
        end
        chk("ill_saturated", 64'(if3.drop_cnt), 64'd255);

        // Random traffic on all channels against the queue model
        for (int k = 0; k < 600; k++) begin
            rand_cycle(1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            rand_cycle(1'b1);
        end
        #1;
        chk("rnd_final_empty", 64'(if4.y_valid), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
